// File: rtl/mram_access_arbiter.sv
// Round-robin arbiter sharing one async MRAM port between two requesters; one latched command per grant.
// Read rsp at A+1+T_SETUP+T_RD; next accept earliest A+1+T_SETUP+T_X+T_REC; req_ready pulses only in IDLE.
module mram_access_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int T_SETUP = 1,
    parameter int T_WP    = 3,
    parameter int T_RD    = 3,
    parameter int T_REC   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [1:0]            i_req_we,
    input  logic [2*ADDR_W-1:0]   i_req_addr,
    input  logic [2*DATA_W-1:0]   i_req_wdata,
    input  logic [3:0]            i_req_be,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_id,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic [ADDR_W-1:0]     o_mram_addr,
    output logic [DATA_W-1:0]     o_mram_dq_out,
    output logic                  o_mram_dq_oe,
    input  logic [DATA_W-1:0]     i_mram_dq_in,
    output logic                  o_chip_en,
    output logic                  o_write_en,
    output logic                  o_out_en,
    output logic                  o_lower_byte_en,
    output logic                  o_upper_byte_en,
    output logic                  o_busy
);

    localparam int MAX_A = (T_SETUP > T_WP) ? T_SETUP : T_WP;
    localparam int MAX_B = (T_RD > T_REC) ? T_RD : T_REC;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_WRITE   = 3'd2,
        S_READ    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                r_last_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rsp_id;
    logic                w_grant;
    logic                w_accept;
    logic                w_cnt_done;

    // Both valid: alternate away from the last winner; otherwise the single valid one wins.
    assign w_grant    = (&i_req_valid) ? ~r_last_grant : ~i_req_valid[0];
    assign w_cnt_done = (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_cnt_nxt       = w_cnt_done ? r_cnt : r_cnt - 1'b1;
        w_accept        = 1'b0;
        o_req_ready     = 2'b00;
        o_chip_en       = 1'b1;
        o_write_en      = 1'b1;
        o_out_en        = 1'b1;
        o_lower_byte_en = 1'b1;
        o_upper_byte_en = 1'b1;
        o_mram_dq_oe    = 1'b0;
        o_rsp_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|i_req_valid) begin
                    w_accept     = 1'b1;
                    o_req_ready  = w_grant ? 2'b10 : 2'b01;
                    w_next_state = S_SETUP;
                    w_cnt_nxt    = CW'(T_SETUP - 1);
                end
            end
            S_SETUP, S_WRITE: begin
                o_chip_en       = 1'b0;
                o_lower_byte_en = ~r_be[0];
                o_upper_byte_en = ~r_be[1];
                o_mram_dq_oe    = r_we;
                o_write_en      = (r_state == S_WRITE) ? 1'b0 : 1'b1;
                if (w_cnt_done) begin
                    if (r_state == S_WRITE) begin
                        w_next_state = S_RECOVER;
                        w_cnt_nxt    = CW'(T_REC - 1);
                    end else begin
                        w_next_state = r_we ? S_WRITE : S_READ;
                        w_cnt_nxt    = r_we ? CW'(T_WP - 1) : CW'(T_RD - 1);
                    end
                end
            end
            S_READ: begin
                o_chip_en       = 1'b0;
                o_out_en        = 1'b0;
                o_lower_byte_en = ~r_be[0];
                o_upper_byte_en = ~r_be[1];
                if (w_cnt_done) begin
                    w_next_state = S_RECOVER;
                    w_cnt_nxt    = CW'(T_REC - 1);
                end
            end
            S_RECOVER: begin
                o_rsp_valid = ~r_we && (r_cnt == CW'(T_REC - 1));
                if (w_cnt_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= 2'b00;
            r_rdata      <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_we         <= i_req_we[w_grant];
                r_addr       <= i_req_addr[w_grant*ADDR_W +: ADDR_W];
                r_wdata      <= i_req_wdata[w_grant*DATA_W +: DATA_W];
                r_be         <= i_req_be[w_grant*2 +: 2];
            end
            // A read with no byte lanes enabled is a no-op and returns zero.
            if (r_state == S_READ && w_cnt_done) begin
                r_rdata  <= (r_be == 2'b00) ? '0 : i_mram_dq_in;
                r_rsp_id <= r_last_grant;
            end
        end
    end

    assign o_mram_addr   = r_addr;
    assign o_mram_dq_out = r_wdata;
    assign o_rsp_rdata   = r_rdata;
    assign o_rsp_id      = r_rsp_id;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mram_access_arbiter.sv
// Directed bench for mram_access_arbiter: strobe timing, arbitration order, byte enables and mid-op reset.
module tb_mram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = 2'b00;
    logic [39:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = 4'b0000;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_rdata;
    logic [19:0] mram_addr;
    logic [15:0] mram_dq_out;
    logic        mram_dq_oe;
    logic [15:0] mram_dq_in;
    logic        chip_en, write_en, out_en, lower_byte_en, upper_byte_en, busy;
    logic [15:0] model_dat = 16'hA5A5;
    logic        mon_en = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // MRAM model: returns data only while out_en is low, garbage otherwise.
    assign mram_dq_in = (!out_en) ? model_dat : 16'hDEAD;

    mram_access_arbiter dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_rdata(rsp_rdata),
        .o_mram_addr(mram_addr), .o_mram_dq_out(mram_dq_out), .o_mram_dq_oe(mram_dq_oe),
        .i_mram_dq_in(mram_dq_in),
        .o_chip_en(chip_en), .o_write_en(write_en), .o_out_en(out_en),
        .o_lower_byte_en(lower_byte_en), .o_upper_byte_en(upper_byte_en), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input logic ce, input logic we, input logic oe);
        chk({tag, "_chip_en"}, chip_en, ce);
        chk({tag, "_write_en"}, write_en, we);
        chk({tag, "_out_en"}, out_en, oe);
    endtask

    // Called during accept cycle A of a read; expects rsp exactly at A+5 and idle at A+6.
    task automatic run_read(input string tag, input logic exp_id, input logic [15:0] exp_dat);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) req_valid = 2'b00;
            chk({tag, "_rsp_valid"}, rsp_valid, (k == 5));
            if (k == 5) begin
                chk({tag, "_rsp_id"}, rsp_id, exp_id);
                chk({tag, "_rsp_rdata"}, rsp_rdata, exp_dat);
            end
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("inv_we_oe", write_en | out_en, 1'b1);
            chk("inv_ce", (!chip_en) | (write_en & out_en), 1'b1);
            chk("inv_dq_oe", !(mram_dq_oe && !out_en), 1'b1);
            chk("inv_ready", (req_ready != 2'b11) && !(busy && req_ready != 2'b00), 1'b1);
        end
    end

    initial begin
        int n_grant;
        int last_cyc;
        logic [1:0] exp_ready;

        // 1: reset
        tick(); tick();
        rst_n = 1'b1;
        #1;
        mon_en = 1'b1;
        chk_strobes("rst", 1'b1, 1'b1, 1'b1);
        chk("rst_lbe", lower_byte_en, 1'b1);
        chk("rst_ube", upper_byte_en, 1'b1);
        chk("rst_dq_oe", mram_dq_oe, 1'b0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", mram_addr, 20'h0);

        // 2: write from requester 0
        tick();
        req_valid = 2'b01; req_we = 2'b01;
        req_addr[19:0] = 20'h12345; req_wdata[15:0] = 16'hBEEF; req_be = 4'b0011;
        #1;
        chk("wr_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        req_addr[19:0] = 20'h0; req_wdata[15:0] = 16'h0;
        chk_strobes("wr_setup", 1'b0, 1'b1, 1'b1);
        chk("wr_busy", busy, 1'b1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk_strobes("wr_pulse", 1'b0, 1'b0, 1'b1);
            chk("wr_addr", mram_addr, 20'h12345);
            chk("wr_dq_out", mram_dq_out, 16'hBEEF);
            chk("wr_dq_oe", mram_dq_oe, 1'b1);
            chk("wr_lbe", lower_byte_en, 1'b0);
            chk("wr_ube", upper_byte_en, 1'b0);
        end
        tick();
        chk_strobes("wr_rec", 1'b1, 1'b1, 1'b1);
        chk("wr_rec_dq_oe", mram_dq_oe, 1'b0);
        chk("wr_rec_rsp", rsp_valid, 1'b0);
        tick();
        chk("wr_done_busy", busy, 1'b0);

        // 3: read from requester 1
        req_valid = 2'b10; req_we = 2'b00;
        req_addr[39:20] = 20'h00010; req_be = 4'b1100;
        #1;
        chk("rd_ready", req_ready, 2'b10);
        run_read("rd1", 1'b1, 16'hA5A5);
        chk("rd1_addr", mram_addr, 20'h00010);

        // 4: both requesters writing continuously
        req_valid = 2'b11; req_we = 2'b11; req_be = 4'b1111;
        req_wdata = {16'h2222, 16'h1111};
        #1;
        n_grant = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40 && n_grant < 4; cyc++) begin
            if (req_ready != 2'b00) begin
                exp_ready = (n_grant % 2 == 0) ? 2'b01 : 2'b10;
                chk("rr_grant", req_ready, exp_ready);
                if (n_grant > 0) chk("rr_spacing", cyc - last_cyc, 6);
                last_cyc = cyc;
                n_grant++;
            end
            tick();
        end
        chk("rr_count", n_grant, 4);
        req_valid = 2'b00;
        for (int k = 0; k < 5; k++) tick();
        chk("rr_idle", busy, 1'b0);

        // 5a: write with lower byte only
        req_valid = 2'b01; req_we = 2'b01; req_be = 4'b0001;
        #1;
        chk("be01_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("be01_lbe", lower_byte_en, 1'b0);
        chk("be01_ube", upper_byte_en, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("be01_idle", busy, 1'b0);

        // 5b: read with no byte lanes
        req_valid = 2'b01; req_we = 2'b00; req_be = 4'b0000;
        #1;
        chk("be00_ready", req_ready, 2'b01);
        tick();
        chk("be00_lbe", lower_byte_en, 1'b1);
        chk("be00_ube", upper_byte_en, 1'b1);
        req_valid = 2'b00;
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk("be00_rsp_valid", rsp_valid, (k == 5));
            if (k == 5) chk("be00_rdata", rsp_rdata, 16'h0000);
            if (k == 3) chk("be00_lbe_rd", lower_byte_en & upper_byte_en, 1'b1);
        end

        // 6: reset in the middle of a write
        req_valid = 2'b01; req_we = 2'b01; req_be = 4'b0011;
        req_addr[19:0] = 20'h55555; req_wdata[15:0] = 16'h1234;
        #1;
        chk("abort_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        chk("abort_in_write", write_en, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_strobes("abort", 1'b1, 1'b1, 1'b1);
        chk("abort_dq_oe", mram_dq_oe, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rsp", rsp_valid, 1'b0);
        chk("abort_addr", mram_addr, 20'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_rsp", rsp_valid, 1'b0);
        end
        // After reset requester 0 must win a tie again.
        req_valid = 2'b11; req_we = 2'b00; req_be = 4'b1111;
        model_dat = 16'h3C5A;
        #1;
        chk("post_rst_ready", req_ready, 2'b01);
        run_read("post_rst", 1'b0, 16'h3C5A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
